// File: rtl/lc3b_mem_responder_if.sv
// Two-port LC-3b memory bus: port A (fetch) and port B (data).
// master drives requests, slave answers with resp/rdata.
interface lc3b_mem_responder_if;
  logic        read_a;
  logic        write_a;
  logic [1:0]  wmask_a;
  logic [15:0] address_a;
  logic [15:0] wdata_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;

  modport master (
    output read_a, write_a, wmask_a,
    output address_a, wdata_a,
    input  resp_a, rdata_a,
    output read_b, write_b, wmask_b,
    output address_b, wdata_b,
    input  resp_b, rdata_b
  );

  modport slave (
    input  read_a, write_a, wmask_a,
    input  address_a, wdata_a,
    output resp_a, rdata_a,
    input  read_b, write_b, wmask_b,
    input  address_b, wdata_b,
    output resp_b, rdata_b
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Two-port memory responder over one shared word array,
// round-robin arbitration and fixed response latency.
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input logic clk,
  input logic reset,
  lc3b_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DEPTH = 1 << ADDR_BITS;
  typedef logic [ADDR_BITS-1:0] idx_t;

  logic [15:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  cnt;
  logic        last;
  logic        sel;
  logic        op_wr;
  idx_t        idx;
  logic [15:0] wd;
  logic [1:0]  wm;
  logic        resp_a_q;
  logic        resp_b_q;
  logic [15:0] rdata_a_q;
  logic [15:0] rdata_b_q;

  logic        pend_a;
  logic        pend_b;
  logic        pick_b;
  logic        live_wr;
  idx_t        live_idx;
  logic [15:0] live_wd;
  logic [1:0]  live_wm;

  logic        commit;
  logic        c_sel;
  logic        c_wr;
  idx_t        c_idx;
  logic [15:0] c_wd;
  logic [1:0]  c_wm;

  assign pend_a = bus.read_a | bus.write_a;
  assign pend_b = bus.read_b | bus.write_b;
  assign pick_b = (pend_a & pend_b) ? ~last : pend_b;

  assign live_wr  = pick_b ? bus.write_b : bus.write_a;
  assign live_idx = pick_b ? bus.address_b[ADDR_BITS:1]
                           : bus.address_a[ADDR_BITS:1];
  assign live_wd  = pick_b ? bus.wdata_b : bus.wdata_a;
  assign live_wm  = pick_b ? bus.wmask_b : bus.wmask_a;

  // With LATENCY=1 the access happens on the capture edge itself,
  // so the live request feeds the array instead of the captured one.
  always_comb begin
    commit = 1'b0;
    c_sel  = sel;
    c_wr   = op_wr;
    c_idx  = idx;
    c_wd   = wd;
    c_wm   = wm;
    if (state == IDLE) begin
      commit = (LATENCY == 1) && (pend_a || pend_b);
      c_sel  = pick_b;
      c_wr   = live_wr;
      c_idx  = live_idx;
      c_wd   = live_wd;
      c_wm   = live_wm;
    end else if (state == WAIT) begin
      commit = (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_wr && !reset) begin
      if (c_wm[0]) mem[c_idx][7:0]  <= c_wd[7:0];
      if (c_wm[1]) mem[c_idx][15:8] <= c_wd[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      sel       <= 1'b0;
      op_wr     <= 1'b0;
      idx       <= '0;
      wd        <= 16'h0000;
      wm        <= 2'b00;
      resp_a_q  <= 1'b0;
      resp_b_q  <= 1'b0;
      rdata_a_q <= 16'h0000;
      rdata_b_q <= 16'h0000;
    end else begin
      resp_a_q <= commit & ~c_sel;
      resp_b_q <= commit & c_sel;
      if (commit && !c_wr) begin
        if (c_sel) rdata_b_q <= mem[c_idx];
        else       rdata_a_q <= mem[c_idx];
      end
      unique case (state)
        IDLE: begin
          if (pend_a || pend_b) begin
            sel   <= pick_b;
            last  <= pick_b;
            op_wr <= live_wr;
            idx   <= live_idx;
            wd    <= live_wd;
            wm    <= live_wm;
            cnt   <= 4'(LATENCY - 1);
            state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_a  = resp_a_q;
  assign bus.resp_b  = resp_b_q;
  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: directed plan plus random traffic
// against a transaction-level model on two parameterisations.
module tb_lc3b_mem_responder;
  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        rd [2][2];
  logic        wr [2][2];
  logic [1:0]  wm [2][2];
  logic [15:0] ad [2][2];
  logic [15:0] wd [2][2];
  logic        rsp [2][2];
  logic [15:0] rdt [2][2];

  lc3b_mem_responder_if if0 ();
  lc3b_mem_responder_if if1 ();

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  lc3b_mem_responder #(.ADDR_BITS(4), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  assign if0.read_a    = rd[0][0];
  assign if0.write_a   = wr[0][0];
  assign if0.wmask_a   = wm[0][0];
  assign if0.address_a = ad[0][0];
  assign if0.wdata_a   = wd[0][0];
  assign if0.read_b    = rd[0][1];
  assign if0.write_b   = wr[0][1];
  assign if0.wmask_b   = wm[0][1];
  assign if0.address_b = ad[0][1];
  assign if0.wdata_b   = wd[0][1];
  assign if1.read_a    = rd[1][0];
  assign if1.write_a   = wr[1][0];
  assign if1.wmask_a   = wm[1][0];
  assign if1.address_a = ad[1][0];
  assign if1.wdata_a   = wd[1][0];
  assign if1.read_b    = rd[1][1];
  assign if1.write_b   = wr[1][1];
  assign if1.wmask_b   = wm[1][1];
  assign if1.address_b = ad[1][1];
  assign if1.wdata_b   = wd[1][1];
  assign rsp[0][0] = if0.resp_a;
  assign rsp[0][1] = if0.resp_b;
  assign rsp[1][0] = if1.resp_a;
  assign rsp[1][1] = if1.resp_b;
  assign rdt[0][0] = if0.rdata_a;
  assign rdt[0][1] = if0.rdata_b;
  assign rdt[1][0] = if1.rdata_a;
  assign rdt[1][1] = if1.rdata_b;

  int n_chk = 0;
  int n_fail = 0;

  int          lat_p [2] = '{2, 1};
  int          ab_p  [2] = '{8, 4};
  int          base_p[2] = '{'h40, 8};
  logic [15:0] mm    [2][256];
  logic [15:0] rd_m  [2][2];
  bit          last_m[2];

  bit dual  [2];
  bit prev  [2][2];
  bit pulse [2][2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rsp[d][0] && rsp[d][1]) dual[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (rsp[d][p] && prev[d][p]) pulse[d][p] = 1'b1;
        prev[d][p] = rsp[d][p];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int widx(input int d, input logic [15:0] a);
    return (int'(a) >> 1) & ((1 << ab_p[d]) - 1);
  endfunction

  task automatic apply(input int d, input int p, input req_t r);
    int i;
    i = widx(d, r.addr);
    if (r.wr) begin
      if (r.mask[0]) mm[d][i][7:0]  = r.data[7:0];
      if (r.mask[1]) mm[d][i][15:8] = r.data[15:8];
    end else begin
      rd_m[d][p] = mm[d][i];
    end
  endtask

  task automatic drive(input int d, input int p, input req_t r);
    rd[d][p] = r.rd;
    wr[d][p] = r.wr;
    ad[d][p] = r.addr;
    wd[d][p] = r.data;
    wm[d][p] = r.mask;
  endtask

  task automatic idle(input int d, input int p);
    rd[d][p] = 1'b0;
    wr[d][p] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_m[d] = 1'b1;
      rd_m[d][0] = 16'h0000;
      rd_m[d][1] = 16'h0000;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run(input int d, input bit ea, input req_t ra,
                     input bit eb, input req_t rb,
                     output int la, output int lb,
                     output logic [15:0] da, output logic [15:0] db);
    la = -1;
    lb = -1;
    da = 16'h0;
    db = 16'h0;
    if (ea) drive(d, 0, ra);
    if (eb) drive(d, 1, rb);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ea && la < 0 && rsp[d][0]) begin
        la = n;
        da = rdt[d][0];
      end
      if (eb && lb < 0 && rsp[d][1]) begin
        lb = n;
        db = rdt[d][1];
      end
      @(posedge clk);
      #1;
      if (la >= 0) idle(d, 0);
      if (lb >= 0) idle(d, 1);
      if ((!ea || la >= 0) && (!eb || lb >= 0)) break;
    end
    idle(d, 0);
    idle(d, 1);
  endtask

  task automatic xact(input int d, input bit ea, input req_t ra,
                      input bit eb, input req_t rb);
    int L, ela, elb, la, lb;
    logic [15:0] da, db;
    bit a_first;
    L = lat_p[d];
    ela = L;
    elb = L;
    if (ea && eb) begin
      a_first = last_m[d];
      ela = a_first ? L : 2 * L + 1;
      elb = a_first ? 2 * L + 1 : L;
      if (a_first) begin
        apply(d, 0, ra);
        apply(d, 1, rb);
      end else begin
        apply(d, 1, rb);
        apply(d, 0, ra);
      end
    end else if (ea) begin
      apply(d, 0, ra);
      last_m[d] = 1'b0;
    end else begin
      apply(d, 1, rb);
      last_m[d] = 1'b1;
    end
    run(d, ea, ra, eb, rb, la, lb, da, db);
    if (ea) begin
      check($sformatf("lat_a d%0d", d), la, ela);
      check($sformatf("rdata_a d%0d", d), da, rd_m[d][0]);
    end
    if (eb) begin
      check($sformatf("lat_b d%0d", d), lb, elb);
      check($sformatf("rdata_b d%0d", d), db, rd_m[d][1]);
    end
  endtask

  function automatic req_t mk(input bit w, input logic [15:0] a,
                              input logic [15:0] v, input logic [1:0] m);
    req_t r;
    r.rd = !w;
    r.wr = w;
    r.addr = a;
    r.data = v;
    r.mask = m;
    return r;
  endfunction

  function automatic req_t rnd_req(input int d);
    req_t r;
    int i, msk;
    r.wr = 1'($urandom_range(0, 1));
    r.rd = r.wr ? 1'($urandom_range(0, 1)) : 1'b1;
    i = base_p[d] + int'($urandom_range(0, 7));
    msk = ((1 << ab_p[d]) - 1) << 1;
    r.addr = 16'((int'($urandom) & ~msk) | (i << 1));
    r.data = 16'($urandom);
    r.mask = 2'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle(d, 0);
      idle(d, 1);
    end
    model_reset();
    @(negedge clk);
    check("reset resp_a", rsp[0][0], 0);
    check("reset resp_b", rsp[0][1], 0);
    check("reset rdata_a", rdt[0][0], 16'h0000);
    check("reset rdata_b", rdt[0][1], 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  req_t nr;
  bit   saw;

  initial begin
    nr = mk(1'b0, 16'h0, 16'h0, 2'b00);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        idle(d, p);
        ad[d][p] = 16'h0;
        wd[d][p] = 16'h0;
        wm[d][p] = 2'b00;
      end
    @(posedge clk);
    #1;
    do_reset();

    xact(0, 1, mk(1, 16'h0010, 16'hBEEF, 2'b11), 0, nr);
    xact(0, 1, mk(0, 16'h0010, 16'h0, 2'b00), 0, nr);
    check("beef", rd_m[0][0], 16'hBEEF);
    xact(0, 0, nr, 1, mk(1, 16'h0010, 16'h1234, 2'b01));
    xact(0, 0, nr, 1, mk(0, 16'h0010, 16'h0, 2'b00));
    check("be34", rd_m[0][1], 16'hBE34);
    xact(0, 0, nr, 1, mk(1, 16'h0010, 16'h5600, 2'b10));
    xact(0, 1, mk(0, 16'h0011, 16'h0, 2'b00), 0, nr);
    check("5634", rd_m[0][0], 16'h5634);
    xact(0, 1, mk(1, 16'h0020, 16'h7777, 2'b11), 0, nr);
    xact(0, 0, nr, 1, mk(1, 16'h0030, 16'h1111, 2'b11));
    xact(0, 1, mk(1, 16'h0040, 16'h9999, 2'b00), 0, nr);

    do_reset();
    xact(0, 1, mk(0, 16'h0010, 16'h0, 2'b00),
            1, mk(0, 16'h0020, 16'h0, 2'b00));
    xact(0, 0, nr, 1, mk(0, 16'h0020, 16'h0, 2'b00));
    for (int k = 0; k < 4; k++)
      xact(0, 1, mk(0, 16'h0020, 16'h0, 2'b00),
              1, mk(k[0], 16'h0010, 16'h00C3 + 16'(k), 2'b11));

    drive(0, 1, mk(1, 16'h0030, 16'hAAAA, 2'b11));
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(0, 1);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp[0][1]) saw = 1'b1;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("wait reset resp_b", saw, 0);
    xact(0, 0, nr, 1, mk(0, 16'h0030, 16'h0, 2'b00));
    check("1111", rd_m[0][1], 16'h1111);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        xact(d, 1, mk(1, 16'((base_p[d] + i) << 1),
                      16'($urandom), 2'b11), 0, nr);

    xact(1, 1, mk(1, 16'h0002, 16'h4C3B, 2'b11), 0, nr);
    xact(1, 0, nr, 1, mk(0, 16'h0022, 16'h0, 2'b00));
    check("alias", rd_m[1][1], 16'h4C3B);

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 60; k++) begin
        int sel;
        sel = int'($urandom_range(1, 3));
        xact(d, sel[0], rnd_req(d), sel[1], rnd_req(d));
      end

    for (int d = 0; d < 2; d++) begin
      check($sformatf("dual d%0d", d), dual[d], 0);
      check($sformatf("pulse_a d%0d", d), pulse[d][0], 0);
      check($sformatf("pulse_b d%0d", d), pulse[d][1], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lc3b_mem_responder.md
# lc3b_mem_responder

Memory-side responder for the CPU's two 16-bit memory ports: port A (instruction fetch) and port B (data). It answers `read`/`write` requests with a single-cycle `resp` pulse after a configurable latency. Both ports share one word-organised backing array that performs at most one access at a time. The block sits opposite `cpu` in simulation tops and FPGA bring-up builds, taking the place of the two-port magic memory.

## Interface
Parameters:
- `ADDR_BITS`, default 8: the array holds 2^ADDR_BITS 16-bit words.
- `LATENCY`, default 2, legal range 1..15: cycles from request capture to `resp`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `read_a`  in  1  port A read request.
- `write_a`  in  1  port A write request.
- `wmask_a`  in  2  port A byte enables; bit 0 is the low byte, bit 1 the high byte.
- `address_a`  in  16  port A byte address.
- `wdata_a`  in  16  port A write data.
- `resp_a`  out  1  port A one-cycle completion pulse.
- `rdata_a`  out  16  port A read data, valid while `resp_a`=1.
- `read_b`, `write_b`, `wmask_b`, `address_b`, `wdata_b`, `resp_b`, `rdata_b`: same as port A, for port B.

## Operation
- Handshake: the initiator holds `read`/`write`, `address`, `wdata` and `wmask` stable until it samples `resp`=1, then may change them on that same edge.
- Word index is `address[ADDR_BITS:1]`. `address[0]` and address bits above ADDR_BITS are ignored, so higher addresses alias.
- If `read` and `write` are asserted together on one port, the request is treated as a write.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: choose a pending port. Capture its op, word index, wdata and wmask. Load `cnt`=LATENCY-1. Go to WAIT, or to RESP when LATENCY=1.
  - WAIT: decrement `cnt`. Go to RESP on the edge where `cnt`==1. Unconditionally, so a request withdrawn mid-wait is still completed.
  - RESP: assert `resp` of the served port only. Go to IDLE on the next edge.
- Array access occurs on the edge entering RESP.
  - Write: update only the bytes whose mask bit is 1. `wmask`=00 is a legal no-op write that still gets a `resp`.
  - Read: load the captured word into that port's `rdata` register.
- `rdata_x` changes only on read responses and holds its value otherwise.
- Arbitration: round-robin using a `last` flag (0=A, 1=B).
  - If both ports are pending in IDLE, serve the port not equal to `last`.
  - If one port is pending, serve it.
  - Update `last` on each capture.
- A request held through its own RESP cycle is not re-captured, because the FSM passes through IDLE first. The request seen in IDLE is by protocol a new one.
- The array is not reset; its contents are undefined until written. Simulation builds may preload it with `$readmemh`.

## Timing
- Reset values: `resp_a`=`resp_b`=0, `rdata_a`=`rdata_b`=0x0000, state IDLE, `cnt`=0, `last`=1 (so A wins the first tie).
- Cycle 0 is the IDLE cycle in which the request is first visible. `resp` is high in cycle LATENCY.
- The next IDLE is cycle LATENCY+1, so each access occupies LATENCY+1 cycles.
- For a port losing arbitration: capture happens at the next IDLE, and `resp` comes LATENCY cycles after that. Worst case is 2*(LATENCY+1)-1 cycles.
- `resp_a` and `resp_b` are never high in the same cycle.
- Reset asserted in WAIT: the access is abandoned, no write is committed and no `resp` is issued.
- Reset asserted in RESP: the write is already committed and `resp` drops immediately (asynchronous).
- A read-after-write to the same word from the other port returns the new data, since writes commit before the later capture.

## Test plan
- LATENCY=2: `write_a` @0x0010, data 0xBEEF, wmask 11, in cycle 0 → `resp_a`=1 in cycle 2 only. Then `read_a` @0x0010 in cycle 3 → `resp_a` in cycle 5 with `rdata_a`=0xBEEF.
- Byte mask: `write_b` @0x0010, data 0x1234, wmask 01 → a later read returns 0xBE34. wmask 10 with data 0x5600 → read returns 0x5634. `read_a` @0x0011 → 0x5634.
- Tie: `read_a` @0x0010 and `read_b` @0x0020 both asserted in cycle 0, after reset → `resp_a` in cycle 2, `resp_b` in cycle 5. Never both high together.
- Fairness: B alone served first, then A and B both pending → A served first. Back-to-back ties alternate A, B, A, B.
- Reset in WAIT: `write_b` @0x0030, data 0xAAAA, over old value 0x1111; assert `reset` in cycle 1 → no `resp_b`, and a read after reset returns 0x1111.
- LATENCY=1 and ADDR_BITS=4: write @0x0002 then read @0x0022 (aliases word 1) → `resp` one cycle after capture; read returns the written data.
